vga_timing_gen: RTL and testbench

//   Display timing generator for the 640x480@60Hz VGA path. Drives pixel_x, pixel_y and
//   vid_on into the screen painter, and hsync/vsync to the VGA connector. It divides the
//   100 MHz system clock to a 25 MHz pixel tick and runs the horizontal/vertical raster

---
 rtl/vga_pkg.sv | 43 ++++
 rtl/pixel_tick_div.sv | 33 +++
 rtl/vga_timing_gen.sv | 99 +++++++++
 tb/tb_vga_timing_gen.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480 timing constants, colours and screen-region codes
package vga_pkg;

    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FP      = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BP      = 48;
    localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FP      = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BP      = 33;
    localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam logic [11:0] COLOR_BLACK  = 12'h000;
    localparam logic [11:0] COLOR_WHITE  = 12'hFFF;
    localparam logic [11:0] COLOR_RED    = 12'hF00;
    localparam logic [11:0] COLOR_GREEN  = 12'h0F0;
    localparam logic [11:0] COLOR_BLUE   = 12'h00F;
    localparam logic [11:0] COLOR_YELLOW = 12'hFF0;

    typedef enum logic [2:0] {
        REGION_TOP,
        REGION_TILES_US,
        REGION_TILES_THEM,
        REGION_BOTTOM,
        REGION_ILLEGAL
    } region_t;

    localparam int REGION_Y_TOP    = 100;
    localparam int REGION_Y_BOTTOM = 420;
    localparam int REGION_X_SPLIT  = 320;

    // Classifies a raster position into the painter's screen regions.
    function automatic region_t region_of(input logic [9:0] x, input logic [9:0] y);
        return !(x < 10'(VGA_H_VISIBLE) && y < 10'(VGA_V_VISIBLE)) ? REGION_ILLEGAL :
               y < 10'(REGION_Y_TOP)     ? REGION_TOP    :
               y >= 10'(REGION_Y_BOTTOM) ? REGION_BOTTOM :
               x < 10'(REGION_X_SPLIT)   ? REGION_TILES_US : REGION_TILES_THEM;
    endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// pixel_tick_div: divides clk by CLK_DIV and emits a registered one-clk pix_tick
module pixel_tick_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick_next,
    output logic pix_tick
);

    localparam int W = $clog2(CLK_DIV);

    logic [W-1:0] div;
    logic [W-1:0] div_n;

    // Next divider value; tick_next flags that pix_tick rises on the coming edge.
    always_comb begin
        div_n     = (div == W'(CLK_DIV - 1)) ? '0 : div + W'(1);
        tick_next = (div_n == W'(CLK_DIV - 1));
    end

    // Divider state and its registered tick.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div      <= '0;
            pix_tick <= 1'b0;
        end else begin
            div      <= div_n;
            pix_tick <= tick_next;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480 raster counters and sync decode; `VGA_SYNC_ALIGN_EN delays syncs one pixel
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int H_VISIBLE = VGA_H_VISIBLE,
    parameter int H_FP      = VGA_H_FP,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BP      = VGA_H_BP,
    parameter int V_VISIBLE = VGA_V_VISIBLE,
    parameter int V_FP      = VGA_V_FP,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BP      = VGA_V_BP,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       vid_on,
    output logic       hsync,
    output logic       vsync,
    output logic       pix_tick,
    output logic       frame_start
);

    localparam int H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_VISIBLE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_VISIBLE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC - 1;

    if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 2) begin : g_param_check
        $error("vga_timing_gen: totals must be <= 1024 and CLK_DIV >= 2");
    end

    logic       tick_next;
    logic [9:0] x_n;
    logic [9:0] y_n;
    logic [9:0] sync_x;
    logic [9:0] sync_y;
    logic       sync_en;
    logic       hs_act;
    logic       vs_act;

    pixel_tick_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk       (clk),
        .reset_n   (reset_n),
        .tick_next (tick_next),
        .pix_tick  (pix_tick)
    );

`ifdef VGA_SYNC_ALIGN_EN
    // Syncs sample the pixel being left, so they trail the counters by one pixel.
    assign sync_x  = pixel_x;
    assign sync_y  = pixel_y;
    assign sync_en = pix_tick;
`else
    assign sync_x  = x_n;
    assign sync_y  = y_n;
    assign sync_en = 1'b1;
`endif

    // Next raster position and sync windows.
    always_comb begin
        x_n    = pixel_x;
        y_n    = pixel_y;
        if (pix_tick) begin
            x_n = (pixel_x == 10'(H_TOTAL - 1)) ? '0 : pixel_x + 10'd1;
            if (pixel_x == 10'(H_TOTAL - 1))
                y_n = (pixel_y == 10'(V_TOTAL - 1)) ? '0 : pixel_y + 10'd1;
        end
        hs_act = (sync_x >= 10'(HS_START)) && (sync_x <= 10'(HS_END));
        vs_act = (sync_y >= 10'(VS_START)) && (sync_y <= 10'(VS_END));
    end

    // Output registers, all decoded from next-state counters so they align with pixel_x/pixel_y.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pixel_x     <= '0;
            pixel_y     <= '0;
            vid_on      <= 1'b0;
            hsync       <= !SYNC_POL;
            vsync       <= !SYNC_POL;
            frame_start <= 1'b0;
        end else begin
            pixel_x     <= x_n;
            pixel_y     <= y_n;
            vid_on      <= (x_n < 10'(H_VISIBLE)) && (y_n < 10'(V_VISIBLE));
            frame_start <= tick_next && (x_n == '0) && (y_n == '0);
            if (sync_en) begin
                hsync <= hs_act ? SYNC_POL : !SYNC_POL;
                vsync <= vs_act ? SYNC_POL : !SYNC_POL;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of the full-size generator and a shrunken-raster instance
module tb_vga_timing_gen;

    logic       clk = 1'b0;
    logic       a_rst_n;
    logic       b_rst_n;
    logic [9:0] a_x, a_y, b_x, b_y;
    logic       a_vid, a_hs, a_vs, a_pt, a_fs;
    logic       b_vid, b_hs, b_vs, b_pt, b_fs;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    vga_timing_gen dut_a (
        .clk         (clk),
        .reset_n     (a_rst_n),
        .pixel_x     (a_x),
        .pixel_y     (a_y),
        .vid_on      (a_vid),
        .hsync       (a_hs),
        .vsync       (a_vs),
        .pix_tick    (a_pt),
        .frame_start (a_fs)
    );

    // 16x11 raster, 2 clks/pixel, active-high syncs: h window 10..12, v window 7..8.
    vga_timing_gen #(
        .CLK_DIV(2), .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b1)
    ) dut_b (
        .clk         (clk),
        .reset_n     (b_rst_n),
        .pixel_x     (b_x),
        .pixel_y     (b_y),
        .vid_on      (b_vid),
        .hsync       (b_hs),
        .vsync       (b_vs),
        .pix_tick    (b_pt),
        .frame_start (b_fs)
    );

    task automatic test_reset;
        a_rst_n = 1'b0;
        b_rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({a_pt, a_fs, a_x, a_y, a_vid, a_hs, a_vs} !== {1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1}) begin
                errors++;
                $display("FAIL reset_a cyc %0d: got pt=%b fs=%b x=%0d y=%0d vid=%b hs=%b vs=%b, expected 0 0 0 0 0 1 1",
                         i, a_pt, a_fs, a_x, a_y, a_vid, a_hs, a_vs);
            end
            checks++;
            if ({b_pt, b_fs, b_x, b_y, b_vid, b_hs, b_vs} !== 25'd0) begin
                errors++;
                $display("FAIL reset_b cyc %0d: got pt=%b fs=%b x=%0d y=%0d vid=%b hs=%b vs=%b, expected all 0",
                         i, b_pt, b_fs, b_x, b_y, b_vid, b_hs, b_vs);
            end
        end
    endtask

    task automatic test_line;
        int mdiv = 0, mx = 0, my = 0, hs_cnt = 0, fs_cnt = 0;
        logic mhs = 1'b1, mvs = 1'b1, ehs, evs, ept;
        logic [24:0] exp_v, got_v;
        a_rst_n = 1'b1;
        for (int i = 1; i <= 3240; i++) begin
            @(negedge clk);
            if (mdiv == 3) begin
                mhs = !(mx >= 656 && mx <= 751);
                mvs = !(my >= 490 && my <= 491);
                if (mx == 799) begin
                    mx = 0;
                    my = (my == 524) ? 0 : my + 1;
                end else mx++;
            end
            mdiv = (mdiv + 1) % 4;
            ept  = (mdiv == 3);
`ifdef VGA_SYNC_ALIGN_EN
            ehs = mhs;
            evs = mvs;
`else
            ehs = !(mx >= 656 && mx <= 751);
            evs = !(my >= 490 && my <= 491);
`endif
            exp_v = {ept, ept && mx == 0 && my == 0, 10'(mx), 10'(my), mx < 640 && my < 480, ehs, evs};
            got_v = {a_pt, a_fs, a_x, a_y, a_vid, a_hs, a_vs};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL line cyc %0d: got pt/fs/x/y/vid/hs/vs=%b/%b/%0d/%0d/%b/%b/%b expected %b/%b/%0d/%0d/%b/%b/%b",
                         i, got_v[24], got_v[23], got_v[22:13], got_v[12:3], got_v[2], got_v[1], got_v[0],
                         exp_v[24], exp_v[23], exp_v[22:13], exp_v[12:3], exp_v[2], exp_v[1], exp_v[0]);
            end
            if (a_pt && !a_hs) hs_cnt++;
            if (a_fs) fs_cnt++;
        end
        checks++;
        if (hs_cnt !== 96) begin
            errors++;
            $display("FAIL hsync_width: got %0d active pixels, expected 96", hs_cnt);
        end
        checks++;
        if (fs_cnt !== 1) begin
            errors++;
            $display("FAIL line_frame_start: got %0d pulses, expected 1", fs_cnt);
        end
    endtask

    task automatic test_mid_reset;
        int n = 0;
        while (a_x !== 10'd300 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (a_x !== 10'd300) begin
            errors++;
            $display("FAIL mid_reset_wait: x=%0d after %0d cycles, expected to reach 300", a_x, n);
        end
        a_rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_pt, a_fs, a_x, a_y, a_vid, a_hs, a_vs} !== {1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL mid_reset: got pt=%b fs=%b x=%0d y=%0d vid=%b hs=%b vs=%b, expected 0 0 0 0 0 1 1",
                     a_pt, a_fs, a_x, a_y, a_vid, a_hs, a_vs);
        end
        a_rst_n = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk);
            checks++;
            if (a_pt !== 1'b0 || a_fs !== 1'b0) begin
                errors++;
                $display("FAIL restart_quiet cyc %0d: got pt=%b fs=%b, expected 0 0", i, a_pt, a_fs);
            end
        end
        @(negedge clk);
        checks++;
        if ({a_pt, a_fs, a_x, a_y, a_vid} !== {1'b1, 1'b1, 10'd0, 10'd0, 1'b1}) begin
            errors++;
            $display("FAIL restart_tick: got pt=%b fs=%b x=%0d y=%0d vid=%b, expected 1 1 0 0 1",
                     a_pt, a_fs, a_x, a_y, a_vid);
        end
    endtask

    task automatic test_frame;
        int mdiv = 0, mx = 0, my = 0, vis_cnt = 0, fs_cnt = 0;
        logic mhs = 1'b0, mvs = 1'b0, ehs, evs, ept;
        logic [24:0] exp_v, got_v;
        b_rst_n = 1'b1;
        for (int i = 1; i <= 704; i++) begin
            @(negedge clk);
            if (mdiv == 1) begin
                mhs = (mx >= 10 && mx <= 12);
                mvs = (my >= 7 && my <= 8);
                if (mx == 15) begin
                    mx = 0;
                    my = (my == 10) ? 0 : my + 1;
                end else mx++;
            end
            mdiv = (mdiv + 1) % 2;
            ept  = (mdiv == 1);
`ifdef VGA_SYNC_ALIGN_EN
            ehs = mhs;
            evs = mvs;
`else
            ehs = (mx >= 10 && mx <= 12);
            evs = (my >= 7 && my <= 8);
`endif
            exp_v = {ept, ept && mx == 0 && my == 0, 10'(mx), 10'(my), mx < 8 && my < 6, ehs, evs};
            got_v = {b_pt, b_fs, b_x, b_y, b_vid, b_hs, b_vs};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL frame cyc %0d: got pt/fs/x/y/vid/hs/vs=%b/%b/%0d/%0d/%b/%b/%b expected %b/%b/%0d/%0d/%b/%b/%b",
                         i, got_v[24], got_v[23], got_v[22:13], got_v[12:3], got_v[2], got_v[1], got_v[0],
                         exp_v[24], exp_v[23], exp_v[22:13], exp_v[12:3], exp_v[2], exp_v[1], exp_v[0]);
            end
            if (b_pt && b_vid) vis_cnt++;
            if (b_fs) fs_cnt++;
        end
        checks++;
        if (vis_cnt !== 96) begin
            errors++;
            $display("FAIL visible_ticks: got %0d over 2 frames, expected 96", vis_cnt);
        end
        checks++;
        if (fs_cnt !== 2) begin
            errors++;
            $display("FAIL frame_start_count: got %0d over 2 frames, expected 2", fs_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_mid_reset();
        test_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
